// File: rtl/sdp_pkg.sv
// Shared definitions for the windowed statistics stage: FSM state type,
// window-size limits and a constant-foldable log2 helper.
package sdp_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } sdp_acc_state_t;

    localparam int WINDOW_MIN = 32'sd2;
    localparam int WINDOW_MAX = 32'sd256;

    // Ceiling log2; exact for the power-of-two windows this stage accepts.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 32'sd0;
        rem    = value - 32'sd1;
        while (rem > 32'sd0) begin
            result = result + 32'sd1;
            rem    = rem >>> 1;
        end
        return result;
    endfunction

    function automatic bit window_ok(input int w);
        return (w >= WINDOW_MIN) && (w <= WINDOW_MAX) && ((w & (w - 32'sd1)) == 32'sd0);
    endfunction

endpackage

// File: rtl/sdp_minmax.sv
// Registered signed running maximum/minimum pair. Exposes the post-update
// values so the parent can capture a final result that includes the current sample.
module sdp_minmax #(
    parameter int ZWIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     load,
    input  logic                     update,
    input  logic signed [ZWIDTH-1:0] d,
    output logic signed [ZWIDTH-1:0] zmax_next,
    output logic signed [ZWIDTH-1:0] zmin_next
);

    logic signed [ZWIDTH-1:0] zmax_r;
    logic signed [ZWIDTH-1:0] zmin_r;

    // Candidate extremes: a load restarts tracking from d, otherwise signed compare.
    always_comb begin
        zmax_next = zmax_r;
        zmin_next = zmin_r;
        if (load) begin
            zmax_next = d;
            zmin_next = d;
        end else begin
            if (d > zmax_r) begin
                zmax_next = d;
            end else begin
                zmax_next = zmax_r;
            end
            if (d < zmin_r) begin
                zmin_next = d;
            end else begin
                zmin_next = zmin_r;
            end
        end
    end

    // Running extreme registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            zmax_r <= {ZWIDTH{1'b0}};
            zmin_r <= {ZWIDTH{1'b0}};
        end else if (clr) begin
            zmax_r <= {ZWIDTH{1'b0}};
            zmin_r <= {ZWIDTH{1'b0}};
        end else if (load || update) begin
            zmax_r <= zmax_next;
            zmin_r <= zmin_next;
        end else begin
            zmax_r <= zmax_r;
            zmin_r <= zmin_r;
        end
    end

endmodule

// File: rtl/sdp_window_accum.sv
// Windowed sum / floor-mean of x and min/max of z over WINDOW accepted samples,
// with the result held behind a valid/ready handshake.
module sdp_window_accum
    import sdp_pkg::*;
#(
    parameter int  DATAWIDTH = 16,
    parameter int  ZWIDTH    = 8,
    parameter int  WINDOW    = 8,
    localparam int LOG2W     = clog2(WINDOW),
    localparam int SUMWIDTH  = DATAWIDTH + LOG2W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [DATAWIDTH-1:0] x,
    input  logic signed [ZWIDTH-1:0]    z,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [SUMWIDTH-1:0]  sum,
    output logic signed [DATAWIDTH-1:0] mean,
    output logic signed [ZWIDTH-1:0]    zmax,
    output logic signed [ZWIDTH-1:0]    zmin
);

    if (!window_ok(WINDOW)) begin : g_bad_window
        $error("sdp_window_accum: WINDOW must be a power of two in 2..256");
    end

    localparam logic [LOG2W-1:0] CNT_LAST = LOG2W'(WINDOW - 1);

    sdp_acc_state_t              state_r;
    sdp_acc_state_t              state_s;
    logic [LOG2W-1:0]            cnt_r;
    logic signed [SUMWIDTH-1:0]  acc_r;
    logic signed [SUMWIDTH-1:0]  acc_next_s;
    logic                        accept_s;
    logic                        first_s;
    logic                        last_s;
    logic signed [ZWIDTH-1:0]    zmax_next_s;
    logic signed [ZWIDTH-1:0]    zmin_next_s;

    assign in_ready  = (state_r == ACCUM);
    assign out_valid = (state_r == HOLD);

    // Accept qualification and the accumulator value including the current sample.
    always_comb begin
        accept_s   = in_valid & in_ready & ~clr;
        first_s    = (cnt_r == {LOG2W{1'b0}});
        last_s     = (cnt_r == CNT_LAST);
        acc_next_s = acc_r + {{LOG2W{x[DATAWIDTH-1]}}, x};
    end

    // Next-state logic; clr wins over both completion and the handshake.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ACCUM: begin
                if (clr) begin
                    state_s = ACCUM;
                end else if (accept_s && last_s) begin
                    state_s = HOLD;
                end else begin
                    state_s = ACCUM;
                end
            end
            HOLD: begin
                if (clr || out_ready) begin
                    state_s = ACCUM;
                end else begin
                    state_s = HOLD;
                end
            end
            default: state_s = ACCUM;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ACCUM;
        end else begin
            state_r <= state_s;
        end
    end

    // Partial-window accumulator and sample counter; both restart after the last sample.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_r <= {SUMWIDTH{1'b0}};
            cnt_r <= {LOG2W{1'b0}};
        end else if (clr) begin
            acc_r <= {SUMWIDTH{1'b0}};
            cnt_r <= {LOG2W{1'b0}};
        end else if (accept_s) begin
            if (last_s) begin
                acc_r <= {SUMWIDTH{1'b0}};
                cnt_r <= {LOG2W{1'b0}};
            end else begin
                acc_r <= acc_next_s;
                cnt_r <= cnt_r + LOG2W'(1);
            end
        end else begin
            acc_r <= acc_r;
            cnt_r <= cnt_r;
        end
    end

    sdp_minmax #(
        .ZWIDTH (ZWIDTH)
    ) u_minmax (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .load      (accept_s & first_s),
        .update    (accept_s & ~first_s),
        .d         (z),
        .zmax_next (zmax_next_s),
        .zmin_next (zmin_next_s)
    );

    // Result registers load only on the completing accept; the mean's bit slice is
    // exactly an arithmetic shift, so it floors toward minus infinity.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum  <= {SUMWIDTH{1'b0}};
            mean <= {DATAWIDTH{1'b0}};
            zmax <= {ZWIDTH{1'b0}};
            zmin <= {ZWIDTH{1'b0}};
        end else if (accept_s && last_s) begin
            sum  <= acc_next_s;
            mean <= acc_next_s[LOG2W +: DATAWIDTH];
            zmax <= zmax_next_s;
            zmin <= zmin_next_s;
        end else begin
            sum  <= sum;
            mean <= mean;
            zmax <= zmax;
            zmin <= zmin;
        end
    end

endmodule
